// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: funct3 encodings, FSM state type and funct3 legality check for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, RD, CAP, WR} lsu_state_t;
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return we ? !(f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {3'b011, 3'b110, 3'b111});
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and word-memory signals; slave = LSU, master = core plus memory
interface load_store_unit_if #(parameter int ADDR_W = 14, parameter int XLEN = 32);
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [XLEN-1:0]   wdata;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   rdata;
  logic              fault;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [XLEN-1:0]   mem_write_data;
  logic [XLEN-1:0]   mem_read_data;
  modport slave (
    input  req, we, funct3, addr, wdata, mem_read_data,
    output busy, done, rdata, fault, mem_read, mem_write, mem_address, mem_write_data
  );
  modport master (
    output req, we, funct3, addr, wdata, mem_read_data,
    input  busy, done, rdata, fault, mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: lane extraction with sign/zero extension for loads and byte/halfword merge for stores
module lsu_align import lsu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr,
  input  logic [XLEN-1:0] i_mem_word,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_load,
  output logic [XLEN-1:0] o_merged
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;
  always_comb begin
    w_byte   = i_mem_word[{i_addr, 3'b000} +: 8];
    w_half   = i_mem_word[{i_addr[1], 4'b0000} +: 16];
    w_sext   = ~i_funct3[2];
    o_load   = i_funct3[1:0] == F3_B[1:0] ? {{(XLEN-8){w_byte[7] & w_sext}}, w_byte} :
               i_funct3[1:0] == F3_H[1:0] ? {{(XLEN-16){w_half[15] & w_sext}}, w_half} : i_mem_word;
    o_merged = i_mem_word;
    if (i_funct3[1:0] == F3_B[1:0]) o_merged[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
    else if (i_funct3[1:0] == F3_H[1:0]) o_merged[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
    else o_merged = i_wdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte-addressed load/store FSM over a word memory (ports clk, reset, bus slave; LSU_MISALIGN_TRAP_EN makes misaligned H/W accesses fault)
module load_store_unit import lsu_pkg::*; #(
  parameter int ADDR_W = 14,
  parameter int XLEN   = 32
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  lsu_state_t        r_state, w_next;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W+1:0] r_addr;
  logic [XLEN-1:0]   r_wword;
  logic [XLEN-1:0]   r_rdata;
  logic              r_done;
  logic              r_fault;
  logic              w_misalign;
  logic              w_fault;
  logic [XLEN-1:0]   w_load;
  logic [XLEN-1:0]   w_merged;
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = (bus.funct3[1:0] == F3_H[1:0] && bus.addr[0]) ||
                      (bus.funct3 == F3_W && bus.addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_fault = f3_illegal(bus.we, bus.funct3) | w_misalign;
  lsu_align #(.XLEN(XLEN)) u_align (
    .i_funct3  (r_f3),
    .i_addr    (r_addr[1:0]),
    .i_mem_word(bus.mem_read_data),
    .i_wdata   (r_wword),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == RD  ? CAP :
             r_state == CAP ? (r_we ? WR : IDLE) :
             r_state == WR  ? IDLE :
             !bus.req || w_fault ? IDLE :
             (bus.we && bus.funct3 == F3_W) ? WR : RD;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wword <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      if (r_state == IDLE && bus.req) begin
        r_we    <= bus.we;
        r_f3    <= bus.funct3;
        r_addr  <= bus.addr[ADDR_W+1:0];
        r_wword <= bus.wdata;
        if (w_fault) begin
          r_done  <= 1'b1;
          r_fault <= 1'b1;
          if (!bus.we) r_rdata <= '0;
        end
      end
      if (r_state == CAP && r_we) r_wword <= w_merged;
      if (r_state == CAP && !r_we) begin
        r_rdata <= w_load;
        r_done  <= 1'b1;
      end
      if (r_state == WR) r_done <= 1'b1;
    end
  end
  always_comb begin
    bus.busy           = r_state != IDLE;
    bus.mem_read       = r_state == RD;
    bus.mem_write      = r_state == WR;
    bus.mem_address    = r_addr[ADDR_W+1:2];
    bus.mem_write_data = r_wword;
    bus.rdata          = r_rdata;
    bus.done           = r_done;
    bus.fault          = r_fault;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a byte-level reference model
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_total = 0;
  int n_bad = 0;
  logic [31:0] dmem    [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [31:0] ref_rdata = 32'h0;
  load_store_unit_if bus();
  load_store_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.mem_read) bus.mem_read_data <= dmem[bus.mem_address];
    else if (bus.mem_write) dmem[bus.mem_address] <= bus.mem_write_data;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic flt, output int lat);
    logic [31:0] w, v;
    int sh, hs, idx;
    idx = int'(a[15:2]);
    sh  = 8 * int'(a[1:0]);
    hs  = 16 * int'(a[1]);
    flt = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd3, 3'd6, 3'd7});
`ifdef LSU_MISALIGN_TRAP_EN
    if (((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0)) flt = 1'b1;
`endif
    w = ref_mem[idx];
    if (flt) begin
      lat = 1;
      if (!we) ref_rdata = 32'h0;
    end else if (!we) begin
      lat = 3;
      case (f3)
        3'd0: begin v = (w >> sh) & 32'hFF; if (v >= 32'h80) v = v | 32'hFFFF_FF00; end
        3'd4: v = (w >> sh) & 32'hFF;
        3'd1: begin v = (w >> hs) & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
        3'd5: v = (w >> hs) & 32'hFFFF;
        default: v = w;
      endcase
      ref_rdata = v;
    end else begin
      lat = (f3 == 3'd2) ? 2 : 4;
      case (f3)
        3'd0: w = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        3'd1: w = (w & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
        default: w = wd;
      endcase
      ref_mem[idx] = w;
    end
  endtask
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit poke);
    logic flt;
    int lat, k, found, nd, nr, nw;
    model(we, f3, a, wd, flt, lat);
    @(negedge clk);
    bus.req = 1'b1; bus.we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    k = 0; found = 0; nd = 0; nr = 0; nw = 0;
    while (k < 8 && found == 0) begin
      @(negedge clk);
      k++;
      bus.req = (k == 1) && poke && !bus.done;
      if (bus.req) begin
        bus.we = 1'($urandom); bus.funct3 = 3'd2; bus.addr = $urandom; bus.wdata = $urandom;
      end
      chk("rw_excl", {31'h0, bus.mem_read & bus.mem_write}, 32'h0);
      if (bus.mem_write) chk("waddr", {18'h0, bus.mem_address}, {18'h0, a[15:2]});
      nr += int'(bus.mem_read);
      nw += int'(bus.mem_write);
      if (bus.done) begin
        found = k;
        nd++;
        chk("fault", {31'h0, bus.fault}, {31'h0, flt});
        chk("rdata", bus.rdata, ref_rdata);
        chk("busy_done", {31'h0, bus.busy}, 32'h0);
      end
    end
    bus.req = 1'b0;
    if (found == 0) chk("timeout", 32'h0, 32'h1);
    else chk("latency", 32'(found), 32'(lat));
    repeat (4) begin
      @(negedge clk);
      nd += int'(bus.done);
      nr += int'(bus.mem_read);
      nw += int'(bus.mem_write);
    end
    chk("ndone", 32'(nd), 32'h1);
    chk("nread", 32'(nr), {31'h0, !flt && (!we || f3 != 3'd2)});
    chk("nwrite", 32'(nw), {31'h0, !flt && we});
  endtask
  task automatic reset_mid(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int k_at);
    @(negedge clk);
    bus.req = 1'b1; bus.we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (k_at - 1) @(negedge clk);
    chk("pre_busy", {31'h0, bus.busy}, 32'h1);
    chk("pre_mw", {31'h0, bus.mem_write}, {31'h0, k_at == 1});
    reset = 1'b1;
    #1;
    chk("rst_mw", {31'h0, bus.mem_write}, 32'h0);
    chk("rst_mr", {31'h0, bus.mem_read}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    ref_rdata = 32'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    logic [31:0] r;
    for (int i = 0; i < 16384; i++) begin
      r = $urandom;
      dmem[i] = r;
      ref_mem[i] = r;
    end
    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy0", {31'h0, bus.busy}, 32'h0);
    chk("rst_done0", {31'h0, bus.done}, 32'h0);
    chk("rst_fault0", {31'h0, bus.fault}, 32'h0);
    chk("rst_rdata0", bus.rdata, 32'h0);
    chk("rst_mr0", {31'h0, bus.mem_read}, 32'h0);
    chk("rst_mw0", {31'h0, bus.mem_write}, 32'h0);
    chk("rst_ma0", {18'h0, bus.mem_address}, 32'h0);
    chk("rst_mwd0", bus.mem_write_data, 32'h0);
    reset = 1'b0;
    do_op(1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    chk("mem_sw10", dmem[4], 32'hDEADBEEF);
    do_op(0, 3'd2, 32'h10, 32'h0, 0);
    chk("lw10", bus.rdata, 32'hDEADBEEF);
    do_op(1, 3'd2, 32'h20, 32'h80FF7F01, 0);
    do_op(0, 3'd0, 32'h21, 32'h0, 0); chk("lb21", bus.rdata, 32'h0000007F);
    do_op(0, 3'd0, 32'h23, 32'h0, 0); chk("lb23", bus.rdata, 32'hFFFFFF80);
    do_op(0, 3'd4, 32'h22, 32'h0, 0); chk("lbu22", bus.rdata, 32'h000000FF);
    do_op(0, 3'd1, 32'h22, 32'h0, 0); chk("lh22", bus.rdata, 32'hFFFF80FF);
    do_op(0, 3'd5, 32'h22, 32'h0, 0); chk("lhu22", bus.rdata, 32'h000080FF);
    do_op(1, 3'd2, 32'h30, 32'h11223344, 0);
    do_op(1, 3'd0, 32'h31, 32'h000000AB, 0);
    do_op(0, 3'd2, 32'h30, 32'h0, 0); chk("sb31", bus.rdata, 32'h1122AB44);
    do_op(1, 3'd1, 32'h32, 32'h0000CDEF, 0);
    do_op(0, 3'd2, 32'h30, 32'h0, 0); chk("sh32", bus.rdata, 32'hCDEFAB44);
    do_op(1, 3'd2, 32'h40, 32'h01234567, 0);
    do_op(0, 3'd2, 32'h41, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw41", bus.rdata, 32'h0);
`else
    chk("lw41", bus.rdata, 32'h01234567);
`endif
    do_op(0, 3'd3, 32'h40, 32'h0, 0);
    do_op(1, 3'd4, 32'h40, 32'hFFFFFFFF, 0);
    do_op(0, 3'd2, 32'h1_0040, 32'h0, 0);
    do_op(1, 3'd2, 32'h50, 32'h5555AAAA, 0);
    reset_mid(1, 3'd2, 32'h50, 32'h12345678, 1);
    do_op(0, 3'd2, 32'h50, 32'h0, 0); chk("rst_wr_keep", bus.rdata, 32'h5555AAAA);
    reset_mid(1, 3'd0, 32'h50, 32'h000000EE, 2);
    do_op(0, 3'd2, 32'h50, 32'h0, 0); chk("rst_cap_keep", bus.rdata, 32'h5555AAAA);
    do_op(0, 3'd2, 32'h10, 32'h0, 1);
    do_op(1, 3'd0, 32'h12, 32'h77, 1);
    do_op(1, 3'd2, 32'h14, 32'hCAFEF00D, 1);
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      do_op(1'($urandom), 3'($urandom), {r[31:16], 8'h0, r[7:0]}, $urandom, $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store front end between the core's execute stage and the word-only `Data_memory` (16K × 32, one-cycle registered read, read priority over write). It decodes RV32I `funct3` and handles all 32-bit transfers. Loads are sign- or zero-extended. SB/SH are done as read-modify-write. Misaligned and illegal accesses are reported as faults.

## Interface
Parameters:
- `ADDR_W`, 14: word-address width toward data memory.
- `XLEN`, 32: data width.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 1: request strobe, sampled in IDLE only.
- `we` in 1: 1 = store, 0 = load.
- `funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in 32: byte address.
- `wdata` in 32: store data, LSB-aligned.
- `busy` out 1: FSM not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: load result, valid while `done`=1.
- `fault` out 1: valid with `done`; misaligned or illegal access.
- `mem_read` out 1: to `Data_memory`.
- `mem_write` out 1: to `Data_memory`.
- `mem_address` out 14: word address, `addr[15:2]`.
- `mem_write_data` out 32: write data.
- `mem_read_data` in 32: from `Data_memory`.

## Operation
- FSM states: IDLE, RD, CAP, WR.
- **IDLE, `req`=1:**
  - Latch `we`, `funct3`, `addr`, `wdata`.
  - Legal load → RD.
  - SW → WR.
  - SB/SH → RD.
  - Fault → IDLE; `done`=1 and `fault`=1 registered on the same edge, no memory access.
- **RD:** `mem_read`=1 → CAP.
- **CAP:** `mem_read_data` is valid this cycle.
  - Load: register the extracted lane into `rdata`, pulse `done`, → IDLE.
  - SB/SH: register the merged word, → WR.
- **WR:** `mem_write`=1 with the full or merged word. Register the `done` pulse, → IDLE.
- **Extraction:**
  - Byte lane is `addr[1:0]`; halfword lane is `addr[1]`.
  - B/H sign-extend; BU/HU zero-extend.
- **Merge:** SB replaces byte `addr[1:0]` with `wdata[7:0]`. SH replaces halfword `addr[1]` with `wdata[15:0]`.
- **Illegal `funct3`:**
  - Loads: 011, 110, 111.
  - Stores: anything other than 000/001/010.
- **Upper address bits:** `addr[31:16]` is ignored, so accesses wrap modulo 64 KB.
- `mem_read` and `mem_write` are never high together.
- `req` while `busy` is ignored and not queued.
- Memory-side outputs decode from state and latched registers, with no combinational path from `req`.

## Timing
- **Latency**, counted from the edge that samples `req` to the cycle in which `done`=1:
  - LW/LB/LH/LBU/LHU: 3 cycles.
  - SW: 2 cycles.
  - SB/SH: 4 cycles.
  - Fault: 1 cycle.
- Back-to-back: a new `req` is accepted in the cycle `done`=1, since the FSM is already in IDLE.
- **Reset values:**
  - State IDLE; `busy`=0, `done`=0, `fault`=0.
  - `rdata`=0, `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_write_data`=0.
- **Reset during an operation:**
  - Reset asserted during WR before the clock edge: `mem_write` drops asynchronously and no write is committed.
  - Reset during CAP of an SB/SH: memory is left unmodified.
- `rdata` holds its last value until the next load's CAP.
- `rdata` is cleared to 0 on a faulting load.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:**
  - H/HU/SH with `addr[0]`=1 fault.
  - W/SW with `addr[1:0]`≠0 fault.
- **Undefined:**
  - Low address bits are truncated to natural alignment: halfword uses `addr[1]` only; word ignores `addr[1:0]`.
  - The access proceeds; only illegal `funct3` faults.

## Structure
- Package `lsu_pkg`:
  - `funct3` constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - `lsu_state_t` enum {IDLE, RD, CAP, WR}.
- Sub-module `lsu_align`, purely combinational:
  - Inputs: `funct3`, `addr[1:0]`, memory word, `wdata`.
  - Outputs: extended load value, merged store word.

## Test plan
- **Word round trip:** SW `addr`=0x0000_0010, `wdata`=0xDEADBEEF, then LW at the same address.
  - `mem_write` is high 1 cycle with `mem_address`=4.
  - LW returns `rdata`=0xDEADBEEF, `fault`=0, with `done` 3 cycles after `req`.
- **Sign/zero extension:** with word 0x80FF_7F01 at 0x20:
  - LB 0x21 → 0x0000_007F.
  - LB 0x23 → 0xFFFF_FF80.
  - LBU 0x22 → 0x0000_00FF.
  - LH 0x22 → 0xFFFF_80FF.
  - LHU 0x22 → 0x0000_80FF.
- **Read-modify-write:** with word 0x1122_3344 at 0x30:
  - SB 0x31 `wdata`=0xAB; LW → 0x1122_AB44.
  - SH 0x32 `wdata`=0xCDEF; LW → 0xCDEF_AB44.
  - `mem_read`/`mem_write` are never high in the same cycle; SB/SH latency is 4.
- **Misaligned with `LSU_MISALIGN_TRAP_EN` defined:** LW 0x41 → `done`=1 and `fault`=1 one cycle after `req`, `rdata`=0, no `mem_read`/`mem_write`.
- **Misaligned with the macro undefined:** same LW returns the word at 0x40.
- **Reset and busy:**
  - Assert `reset` during WR of an SW to 0x50 → `mem_write` low immediately; a later LW 0x50 returns the old value.
  - `req` pulsed while `busy`=1 → ignored, exactly one `done`.
